// File: rtl/ahb_decoder_mux.sv
// AHB address decoder and slave-to-master response mux, with an internal
// default slave that returns a two-cycle ERROR to active transfers to unmapped regions.
module ahb_decoder_mux #(
    parameter int NUM_SLAVES   = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int REGION_SHIFT = 28
) (
    input  logic                             Hclk,
    input  logic                             Hresetn,
    input  logic [ADDR_WIDTH-1:0]            Haddr,
    input  logic [1:0]                       Htrans,
    input  logic [NUM_SLAVES-1:0]            Hreadyout_s,
    input  logic [NUM_SLAVES-1:0]            Hresp_s,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] Hrdata_s,
    output logic [NUM_SLAVES-1:0]            Hsel,
    output logic                             Hready,
    output logic                             Hresp,
    output logic [DATA_WIDTH-1:0]            Hrdata,
    output logic [7:0]                       decode_err_cnt
);
    localparam int RW = ADDR_WIDTH - REGION_SHIFT;
    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

    logic [RW-1:0]   region;
    logic [31:0]     region_ext;
    logic [IW-1:0]   region_idx;
    logic            mapped;
    logic            err_start;
    logic            unused_bits;

    logic            dsel_def;
    logic [IW-1:0]   dsel_idx;

    ds_state_t       ds_state, ds_next;
    logic            ds_ready, ds_resp;

    logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] rdata_arr;

    assign region      = Haddr[ADDR_WIDTH-1:REGION_SHIFT];
    assign region_ext  = 32'(region);
    assign region_idx  = region[IW-1:0];
    assign mapped      = region_ext < 32'(NUM_SLAVES);
    assign unused_bits = ^{Haddr[REGION_SHIFT-1:0], Htrans[0]};
    assign rdata_arr   = Hrdata_s;

    // Only NONSEQ/SEQ (Htrans[1]=1) accepted on unmapped space are errors.
    assign err_start = Hready && Htrans[1] && !mapped;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            assign Hsel[gi] = (region_ext == 32'(gi));
        end
    endgenerate

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            dsel_def <= 1'b1;
            dsel_idx <= '0;
        end else if (Hready) begin
            dsel_def <= !mapped;
            dsel_idx <= mapped ? region_idx : '0;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) ds_state <= DS_IDLE;
        else          ds_state <= ds_next;
    end

    always_comb begin
        ds_next = ds_state;
        case (ds_state)
            DS_IDLE: if (err_start) ds_next = DS_ERR1;
            DS_ERR1: ds_next = DS_ERR2;
            DS_ERR2: ds_next = err_start ? DS_ERR1 : DS_IDLE;
            default: ds_next = DS_IDLE;
        endcase
    end

    always_comb begin
        ds_ready = 1'b1;
        ds_resp  = 1'b0;
        case (ds_state)
            DS_ERR1: begin ds_ready = 1'b0; ds_resp = 1'b1; end
            DS_ERR2: begin ds_ready = 1'b1; ds_resp = 1'b1; end
            default: begin ds_ready = 1'b1; ds_resp = 1'b0; end
        endcase
    end

    always_comb begin
        Hready = ds_ready;
        Hresp  = ds_resp;
        Hrdata = '0;
        if (!dsel_def) begin
            Hready = Hreadyout_s[dsel_idx];
            Hresp  = Hresp_s[dsel_idx];
            Hrdata = rdata_arr[dsel_idx];
        end
    end

    // ERR1 is only reachable from IDLE/ERR2, so every entry is a new error.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn)
            decode_err_cnt <= 8'd0;
        else if (ds_next == DS_ERR1 && decode_err_cnt != 8'hFF)
            decode_err_cnt <= decode_err_cnt + 8'd1;
    end
endmodule
